md5_target_sequencer: RTL and testbench
=======================================

# md5_target_sequencer

Controller that walks the 16-entry MD5 target-hash table through a contiguous index range and runs one brute-force search per target. For each index it drives the table's 4-bit selector, waits for the registered 128-bit hash, pulses a load into the cracker core, starts the search and waits for found or exhausted. It then hands one result record per target to the host/UART side over a valid/ready port. It sits between the host command decoder and the counter/MD5 pipeline and is the only driver of the table selector.

## Interface
- SETTLE_CYCLES, 1, cycles spent in SETTLE after `sel` changes, before `target_load`; minimum 1, which covers the table's one-cycle registered output.
- TIMEOUT_CYCLES, 32'd100000000, per-target search limit in CLK cycles; used only with MD5_SEQ_TIMEOUT_EN.
- CLK  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; accepted only in IDLE, ignored otherwise.
- abort  in  1  forces IDLE from any state.
- first_idx  in  4  first target index; sampled when start is accepted.
- last_idx  in  4  last target index; sampled when start is accepted.
- sel  out  4  table selector, registered.
- target_load  out  1  one-cycle pulse; the cracker latches the 128-bit hash on it.
- search_start  out  1  one-cycle pulse; the cracker begins counting on it.
- search_found  in  1  cracker matched; `search_word` is valid in the same cycle.
- search_word  in  32  matching preimage.
- search_exhausted  in  1  keyspace finished with no match.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts the record.
- res_idx  out  4  target index of the record.
- res_found  out  1  1 if a match was found.
- res_word  out  32  preimage; 0 when not found.
- res_timeout  out  1  1 if the target timed out.
- busy  out  1  high in every state except IDLE.
- run_done  out  1  one-cycle pulse after the last record is accepted.

## Operation
- States: IDLE, SETTLE, LOAD, START, RUN, REPORT.
- IDLE: on `start`:
  - latch first_idx into cur and last_idx into end;
  - set sel <= first_idx;
  - go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to LOAD.
- LOAD: target_load=1 for one cycle, then go to START.
- START: search_start=1 for one cycle, then go to RUN.
- RUN: wait for an event, then capture the record and go to REPORT.
  - search_found: res_found=1, res_word=search_word.
  - search_exhausted: res_found=0, res_word=0.
  - search_found and search_exhausted in the same cycle: found wins.
- REPORT: hold res_valid=1 with stable fields until res_valid && res_ready.
  - If cur==end: pulse run_done and go to IDLE.
  - Otherwise: cur <= cur+1 (mod 16), sel <= cur+1, go to SETTLE.
- Range rules:
  - The index increments modulo 16, so last_idx < first_idx wraps 15→0.
  - first_idx == last_idx runs exactly one target.
  - A full 16-target run is first_idx=last_idx+1 (mod 16); e.g. 0..15 is first=0, last=15.
- search_found and search_exhausted are ignored outside RUN.
- `abort` (any state) and `reset` both:
  - clear all outputs to their reset values;
  - drop res_valid without completing the handshake;
  - do not pulse run_done.
  - abort has priority over every other input in the same cycle.
- Reset values: sel=0, target_load=0, search_start=0, res_valid=0, res_idx=0, res_found=0, res_word=0, res_timeout=0, busy=0, run_done=0, state=IDLE.

## Timing
- Start accepted in cycle 0, with SETTLE_CYCLES=1:
  - sel=first from cycle 1;
  - table output valid from cycle 2;
  - target_load in cycle 2;
  - search_start in cycle 3;
  - RUN from cycle 4.
- In general, target_load occurs in cycle 1+SETTLE_CYCLES.
- search_found in RUN cycle t → res_valid=1 from cycle t+1.
- Handshake accepted in cycle r → sel=next index in cycle r+1, and the next target_load follows SETTLE_CYCLES cycles after that.
- Last record accepted in cycle r → run_done=1 and busy=1 in cycle r+1, then busy=0 and IDLE in cycle r+2.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- MD5_SEQ_TIMEOUT_EN defined:
  - A 32-bit counter clears on entry to RUN and increments every RUN cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 with no event, the record is captured with res_found=0, res_word=0, res_timeout=1.
  - A search_found in the same cycle as expiry wins, giving res_timeout=0.
- MD5_SEQ_TIMEOUT_EN undefined:
  - No counter is implemented; RUN waits indefinitely.
  - res_timeout is tied to 0.

## Test plan
- Single target: start with first=last=10; found in the 5th RUN cycle with word 32'h484f4c41 → exactly one target_load in cycle 2; record idx=10, found=1, word=32'h484f4c41; run_done pulse; then IDLE.
- Wrap range: first=14, last=1; every search exhausted; res_ready tied high → sel sequence 14,15,0,1; four records with found=0 and word=0; one run_done.
- Backpressure and simultaneous events: found and exhausted together on idx 3 with word 32'hbebacafe; res_ready low for 20 cycles → res_valid and fields held stable, found=1; sel does not advance until acceptance.
- Abort mid-RUN on idx 5 → busy=0 next cycle; no record; no run_done. A later start with first=5, last=5 then runs normally.
- Reset asserted in SETTLE → all outputs at reset values next cycle. A start asserted during reset is ignored.
- Timeout (macro defined, TIMEOUT_CYCLES=8): no events → record found=0, timeout=1, exactly 8 RUN cycles after search_start. Macro undefined: no record after 1000 cycles.

Source files
------------

// File: rtl/md5_target_sequencer.sv
// md5_target_sequencer
// Walks the MD5 target-hash table over a contiguous (mod 16) index range and
// runs one brute-force search per target, handing one result record per target
// to the host side over a valid/ready port. All outputs are registered.
// Optional feature: define MD5_SEQ_TIMEOUT_EN to add a per-target search
// timeout of TIMEOUT_CYCLES clock cycles.
//
// state  | meaning
// IDLE   | waiting for start
// SETTLE | sel just changed, waiting for the table's registered output
// LOAD   | target_load pulse (registered, high while in this state)
// START  | search_start pulse (registered, high while in this state)
// RUN    | waiting for found / exhausted (/ timeout)
// REPORT | record held until accepted; res_valid low here means run finishing

module md5_target_sequencer #(
    parameter int          SETTLE_CYCLES  = 1,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  first_idx,
    input  logic [3:0]  last_idx,
    output logic [3:0]  sel,
    output logic        target_load,
    output logic        search_start,
    input  logic        search_found,
    input  logic [31:0] search_word,
    input  logic        search_exhausted,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_idx,
    output logic        res_found,
    output logic [31:0] res_word,
    output logic        res_timeout,
    output logic        busy,
    output logic        run_done
);

    typedef enum logic [2:0] {IDLE, SETTLE, LOAD, START, RUN, REPORT} state_t;

    localparam logic [15:0] SETTLE_INIT = 16'(SETTLE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cur, cur_nxt, end_idx, end_nxt, sel_nxt, res_idx_nxt;
    logic [15:0] settle_cnt, settle_cnt_nxt;
    logic        res_valid_nxt, res_found_nxt, res_timeout_nxt, run_done_nxt;
    logic [31:0] res_word_nxt;
    logic        target_load_nxt, search_start_nxt, busy_nxt;
    logic        tmo_hit;

`ifdef MD5_SEQ_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    // Search timer: zero outside RUN, so it starts from 0 on every RUN entry.
    always_ff @(posedge CLK) begin
        if (reset || state != RUN) tmo_cnt <= '0;
        else                       tmo_cnt <= tmo_cnt + 32'd1;
    end

    assign tmo_hit = (state == RUN) && (tmo_cnt == TIMEOUT_CYCLES - 32'd1);
`else
    logic [31:0] unused_tmo_cycles;
    assign unused_tmo_cycles = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    // Next-state and next-output computation; abort overrides everything.
    always_comb begin
        state_nxt       = state;
        cur_nxt         = cur;
        end_nxt         = end_idx;
        sel_nxt         = sel;
        settle_cnt_nxt  = settle_cnt;
        res_valid_nxt   = res_valid;
        res_idx_nxt     = res_idx;
        res_found_nxt   = res_found;
        res_word_nxt    = res_word;
        res_timeout_nxt = res_timeout;
        run_done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    cur_nxt        = first_idx;
                    end_nxt        = last_idx;
                    sel_nxt        = first_idx;
                    settle_cnt_nxt = SETTLE_INIT;
                    state_nxt      = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == 16'd0) state_nxt = LOAD;
                else                     settle_cnt_nxt = settle_cnt - 16'd1;
            end
            LOAD:  state_nxt = START;
            START: state_nxt = RUN;
            RUN: begin
                if (search_found || search_exhausted || tmo_hit) begin
                    res_valid_nxt   = 1'b1;
                    res_idx_nxt     = cur;
                    res_found_nxt   = search_found;
                    res_word_nxt    = search_found ? search_word : 32'd0;
                    res_timeout_nxt = !search_found && !search_exhausted;
                    state_nxt       = REPORT;
                end
            end
            REPORT: begin
                if (res_valid && res_ready) begin
                    res_valid_nxt = 1'b0;
                    if (cur == end_idx) begin
                        run_done_nxt = 1'b1;
                    end else begin
                        cur_nxt        = cur + 4'd1;
                        sel_nxt        = cur + 4'd1;
                        settle_cnt_nxt = SETTLE_INIT;
                        state_nxt      = SETTLE;
                    end
                end else if (!res_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

`ifndef MD5_SEQ_TIMEOUT_EN
        res_timeout_nxt = 1'b0;
`endif

        if (abort) begin
            state_nxt       = IDLE;
            cur_nxt         = 4'd0;
            end_nxt         = 4'd0;
            sel_nxt         = 4'd0;
            settle_cnt_nxt  = 16'd0;
            res_valid_nxt   = 1'b0;
            res_idx_nxt     = 4'd0;
            res_found_nxt   = 1'b0;
            res_word_nxt    = 32'd0;
            res_timeout_nxt = 1'b0;
            run_done_nxt    = 1'b0;
        end

        target_load_nxt  = (state_nxt == LOAD);
        search_start_nxt = (state_nxt == START);
        busy_nxt         = (state_nxt != IDLE);
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= IDLE;
            cur          <= 4'd0;
            end_idx      <= 4'd0;
            settle_cnt   <= 16'd0;
            sel          <= 4'd0;
            target_load  <= 1'b0;
            search_start <= 1'b0;
            res_valid    <= 1'b0;
            res_idx      <= 4'd0;
            res_found    <= 1'b0;
            res_word     <= 32'd0;
            res_timeout  <= 1'b0;
            busy         <= 1'b0;
            run_done     <= 1'b0;
        end else begin
            state        <= state_nxt;
            cur          <= cur_nxt;
            end_idx      <= end_nxt;
            settle_cnt   <= settle_cnt_nxt;
            sel          <= sel_nxt;
            target_load  <= target_load_nxt;
            search_start <= search_start_nxt;
            res_valid    <= res_valid_nxt;
            res_idx      <= res_idx_nxt;
            res_found    <= res_found_nxt;
            res_word     <= res_word_nxt;
            res_timeout  <= res_timeout_nxt;
            busy         <= busy_nxt;
            run_done     <= run_done_nxt;
        end
    end

endmodule

// File: tb/tb_md5_target_sequencer.sv
// Directed testbench for md5_target_sequencer (SETTLE_CYCLES=1, TIMEOUT_CYCLES=8).
// Define MD5_SEQ_TIMEOUT_EN for both files to exercise the timeout build.

module tb_md5_target_sequencer;

    logic        CLK = 1'b0;
    logic        reset, start, abort;
    logic [3:0]  first_idx, last_idx;
    logic [3:0]  sel;
    logic        target_load, search_start;
    logic        search_found, search_exhausted;
    logic [31:0] search_word;
    logic        res_valid, res_ready;
    logic [3:0]  res_idx;
    logic        res_found, res_timeout;
    logic [31:0] res_word;
    logic        busy, run_done;

    md5_target_sequencer #(.SETTLE_CYCLES(1), .TIMEOUT_CYCLES(32'd8)) dut (
        .CLK(CLK), .reset(reset), .start(start), .abort(abort),
        .first_idx(first_idx), .last_idx(last_idx), .sel(sel),
        .target_load(target_load), .search_start(search_start),
        .search_found(search_found), .search_word(search_word),
        .search_exhausted(search_exhausted), .res_valid(res_valid),
        .res_ready(res_ready), .res_idx(res_idx), .res_found(res_found),
        .res_word(res_word), .res_timeout(res_timeout), .busy(busy),
        .run_done(run_done)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event logs sampled on the falling edge.
    int          tl_count, rd_count;
    logic [3:0]  tl_sel_q[$];
    logic [36:0] rec_q[$];

    always @(negedge CLK) begin
        if (target_load) begin
            tl_count++;
            tl_sel_q.push_back(sel);
        end
        if (run_done) rd_count++;
        if (res_valid && res_ready) rec_q.push_back({res_idx, res_found, res_word});
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        tl_count = 0;
        rd_count = 0;
        tl_sel_q.delete();
        rec_q.delete();
    endtask

    task automatic do_start(input logic [3:0] f, input logic [3:0] l);
        first_idx = f;
        last_idx  = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Waits (bounded) for search_start, then steps into the first RUN cycle.
    task automatic wait_run(input string tag);
        int i = 0;
        while (search_start !== 1'b1 && i < 40) begin
            tick();
            i++;
        end
        check_val({tag, "_search_start"}, search_start, 1'b1);
        tick();
    endtask

    task automatic wait_done(input string tag, input int limit);
        int i = 0;
        while (run_done !== 1'b1 && i < limit) begin
            tick();
            i++;
        end
        check_val({tag, "_run_done"}, run_done, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq;
        logic        any_set;
        int          bad;
        int          k;

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        first_idx = 4'd0; last_idx = 4'd0;
        search_found = 1'b0; search_exhausted = 1'b0; search_word = 32'd0;
        res_ready = 1'b0;
        tick(); tick();
        check_val("rst_sel", sel, 4'd0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_res_valid", res_valid, 1'b0);
        check_val("rst_pulses", {target_load, search_start, run_done}, 3'b000);
        check_val("rst_record", {res_idx, res_found, res_timeout, res_word}, 38'd0);
        reset = 1'b0;
        tick();

        // Single target 10, found in the 5th RUN cycle.
        clear_logs();
        do_start(4'd10, 4'd10);
        check_val("single_sel_c1", sel, 4'd10);
        check_val("single_busy_c1", busy, 1'b1);
        check_val("single_tl_c1", target_load, 1'b0);
        tick();
        check_val("single_tl_c2", target_load, 1'b1);
        tick();
        check_val("single_ss_c3", {target_load, search_start}, 2'b01);
        tick();
        repeat (4) tick();
        check_val("single_no_rec_c8", res_valid, 1'b0);
        search_found = 1'b1; search_word = 32'h484f4c41;
        tick();
        search_found = 1'b0; search_word = 32'd0;
        check_val("single_valid", res_valid, 1'b1);
        check_val("single_record", {res_idx, res_found, res_timeout, res_word}, {4'd10, 2'b10, 32'h484f4c41});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_val("single_done_c", {run_done, busy, res_valid}, 3'b110);
        tick();
        check_val("single_idle", {run_done, busy}, 2'b00);
        check_val("single_tl_count", tl_count, 1);
        check_val("single_rd_count", rd_count, 1);

        // Wrapping range 14..1, all exhausted, consumer always ready.
        clear_logs();
        res_ready = 1'b1; search_exhausted = 1'b1;
        do_start(4'd14, 4'd1);
        wait_done("wrap", 100);
        tick();
        search_exhausted = 1'b0; res_ready = 1'b0;
        seq = 16'd0;
        for (int i = 0; i < tl_sel_q.size() && i < 4; i++) seq = {seq[11:0], tl_sel_q[i]};
        check_val("wrap_tl_count", tl_count, 4);
        check_val("wrap_sel_seq", seq, 16'hEF01);
        seq = 16'd0; any_set = 1'b0;
        for (int i = 0; i < rec_q.size() && i < 4; i++) begin
            seq = {seq[11:0], rec_q[i][36:33]};
            any_set = any_set | rec_q[i][32] | (|rec_q[i][31:0]);
        end
        check_val("wrap_rec_count", rec_q.size(), 4);
        check_val("wrap_rec_idx", seq, 16'hEF01);
        check_val("wrap_rec_zero", any_set, 1'b0);
        check_val("wrap_rd_count", rd_count, 1);
        check_val("wrap_idle", busy, 1'b0);

        // Backpressure with simultaneous found+exhausted on target 3.
        clear_logs();
        do_start(4'd3, 4'd3);
        wait_run("bp");
        search_found = 1'b1; search_exhausted = 1'b1; search_word = 32'hbebacafe;
        tick();
        search_found = 1'b0; search_exhausted = 1'b0; search_word = 32'd0;
        check_val("bp_valid", res_valid, 1'b1);
        check_val("bp_record", {res_idx, res_found, res_timeout, res_word}, {4'd3, 2'b10, 32'hbebacafe});
        bad = 0;
        repeat (20) begin
            tick();
            if (res_valid !== 1'b1 || res_idx !== 4'd3 || res_found !== 1'b1 ||
                res_word !== 32'hbebacafe || res_timeout !== 1'b0 || sel !== 4'd3 ||
                busy !== 1'b1 || run_done !== 1'b0) bad++;
        end
        check_val("bp_stable", bad, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_val("bp_run_done", run_done, 1'b1);
        check_val("bp_rec_count", rec_q.size(), 1);
        tick();

        // Abort mid-RUN on target 5, then a clean single run of 5.
        clear_logs();
        do_start(4'd5, 4'd7);
        wait_run("abort");
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_outs", {busy, res_valid, sel}, {2'b00, 4'd0});
        repeat (10) tick();
        check_val("abort_no_rec", rec_q.size(), 0);
        check_val("abort_no_done", rd_count, 0);
        check_val("abort_tl_count", tl_count, 1);
        do_start(4'd5, 4'd5);
        wait_run("rerun");
        repeat (2) tick();
        search_found = 1'b1; search_word = 32'h12345678;
        tick();
        search_found = 1'b0; search_word = 32'd0;
        check_val("rerun_record", {res_valid, res_idx, res_found, res_word}, {1'b1, 4'd5, 1'b1, 32'h12345678});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_val("rerun_run_done", run_done, 1'b1);
        tick();

        // Reset during SETTLE, with start held during reset.
        clear_logs();
        do_start(4'd9, 4'd9);
        check_val("rstmid_busy", busy, 1'b1);
        reset = 1'b1; start = 1'b1; first_idx = 4'd2; last_idx = 4'd2;
        tick();
        check_val("rstmid_outs", {sel, target_load, search_start, res_valid, busy, run_done}, {4'd0, 5'd0});
        tick();
        reset = 1'b0; start = 1'b0;
        tick();
        check_val("rstmid_start_ignored", busy, 1'b0);
        repeat (5) tick();
        check_val("rstmid_tl_count", tl_count, 0);

        // No events: timeout record (timeout build) or indefinite wait.
        clear_logs();
        do_start(4'd2, 4'd2);
        tick(); tick();
        check_val("tmo_search_start", search_start, 1'b1);
        k = 0;
        tick();
        while (res_valid !== 1'b1 && k < 1000) begin
            k++;
            tick();
        end
`ifdef MD5_SEQ_TIMEOUT_EN
        check_val("tmo_run_cycles", k, 8);
        check_val("tmo_record", {res_valid, res_idx, res_found, res_timeout, res_word}, {1'b1, 4'd2, 2'b01, 32'd0});
`else
        check_val("notmo_no_record", res_valid, 1'b0);
        check_val("notmo_waited", k, 1000);
        check_val("notmo_busy", busy, 1'b1);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("tmo_abort_clear", {busy, res_valid, res_timeout}, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
